// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, bridge FSM states and peripheral register offsets.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  // Register offsets inside the APB window, used by the bench and firmware.
  localparam logic [APB_ADDR_W-1:0] LED = 32'h0000_0000;
  localparam logic [APB_ADDR_W-1:0] SW1 = 32'h0000_0004;
  localparam logic [APB_ADDR_W-1:0] SW2 = 32'h0000_0008;
  localparam logic [APB_ADDR_W-1:0] SEG = 32'h0000_000C;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response channel and APB bus bundle for the master bridge.
interface apb_master_bridge_if
  import apb_pkg::*;
();

  // Core-side request channel
  logic                  req_valid;
  logic                  req_ready;
  logic [APB_ADDR_W-1:0] req_addr;
  logic                  req_write;
  logic [APB_DATA_W-1:0] req_wdata;

  // Core-side response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [APB_DATA_W-1:0] rsp_rdata;
  logic                  rsp_err;

  // APB bus
  logic [APB_ADDR_W-1:0] Paddr;
  logic                  Pwrite;
  logic                  Psel;
  logic                  Penable;
  logic [APB_DATA_W-1:0] Pwdata;
  logic [APB_DATA_W-1:0] Prdata;
  logic                  Pready;
  logic                  Pslverr;

  // Bridge side
  modport master (
    input  req_valid, req_addr, req_write, req_wdata, rsp_ready, Prdata, Pready, Pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, Paddr, Pwrite, Psel, Penable, Pwdata
  );

  // Core plus responder side
  modport slave (
    output req_valid, req_addr, req_write, req_wdata, rsp_ready, Prdata, Pready, Pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, Paddr, Pwrite, Psel, Penable, Pwdata
  );

endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: turns one outstanding valid/ready request into an APB SETUP/ACCESS
// transfer, with window/alignment decode errors and a stuck-slave timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR = 32'h2000_0000,
  parameter logic [APB_ADDR_W-1:0] WIN_SIZE  = 32'h0000_1000,
  parameter int unsigned           TIMEOUT   = 16
) (
  input logic                 Pclk,
  input logic                 Prst_n,
  apb_master_bridge_if.master bus
);

  localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = (TIMEOUT == 0) ? '0 : CntW'(TIMEOUT - 1);

  apb_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic [APB_DATA_W-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;

  logic [APB_ADDR_W:0]   offset;
  logic                  addr_ok;
  logic                  req_hs;

  // One extra bit keeps addresses below BASE_ADDR from wrapping into the window.
  assign offset  = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
  assign addr_ok = !offset[APB_ADDR_W] && (offset[APB_ADDR_W-1:0] < WIN_SIZE) &&
                   (bus.req_addr[1:0] == 2'b00);
  assign req_hs  = bus.req_valid && req_ready_q;

  // Next-state, timeout counter and response capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_hs) begin
          paddr_d  = bus.req_addr;
          pwrite_d = bus.req_write;
          pwdata_d = bus.req_wdata;
          if (addr_ok) begin
            state_d = StSetup;
          end else begin
            state_d = StResp;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = '0;
      end
      StAccess: begin
        if (bus.Pready) begin
          rdata_d = pwrite_q ? '0 : bus.Prdata;
          err_d   = bus.Pslverr;
          state_d = StResp;
        end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Registered so req_ready stays low while reset is held.
    req_ready_d = (state_d == StIdle);
  end

  // State and datapath registers.
  always_ff @(posedge Pclk or negedge Prst_n) begin
    if (!Prst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.Psel      = (state_q == StSetup) || (state_q == StAccess);
  assign bus.Penable   = (state_q == StAccess);
  assign bus.Paddr     = paddr_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, reset-mid-transfer
// sequence and randomized traffic checked against a transaction-level reference model.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam logic [31:0] Base    = 32'h2000_0000;
  localparam logic [31:0] Win     = 32'h0000_1000;
  localparam int unsigned Timeout = 16;

  logic Pclk;
  logic Prst_n;

  apb_master_bridge_if bus ();

  apb_master_bridge #(
    .BASE_ADDR(Base),
    .WIN_SIZE (Win),
    .TIMEOUT  (Timeout)
  ) dut (
    .Pclk  (Pclk),
    .Prst_n(Prst_n),
    .bus   (bus)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  int checks = 0;
  int errors = 0;

  // Responder: 1024-word memory covering the window, programmable wait states.
  int          wait_n    = 0;
  bit          slverr_en = 1'b0;
  int          acc_cnt   = 0;
  logic [31:0] mem     [1024];
  bit          mem_vld [1024];
  logic [31:0] ref_mem [1024];
  bit          ref_vld [1024];
  logic [9:0]  pidx;

  function automatic logic [31:0] dflt(input int i);
    return (i == 1) ? 32'hA5A5_A5A5 : (32'hC0DE_0000 | 32'(i));
  endfunction

  assign pidx        = bus.Paddr[11:2];
  assign bus.Pready  = bus.Psel && bus.Penable && (acc_cnt == wait_n);
  assign bus.Prdata  = mem_vld[pidx] ? mem[pidx] : dflt(int'(pidx));
  assign bus.Pslverr = slverr_en;

  always @(posedge Pclk) begin
    if (bus.Psel && bus.Penable && !bus.Pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (bus.Psel && bus.Penable && bus.Pready && bus.Pwrite && !slverr_en) begin
      mem[pidx]     <= bus.Pwdata;
      mem_vld[pidx] <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level model: outcome of one request from the address rules, wait count
  // and responder error, plus the memory contents seen through the bridge.
  function automatic void ref_model(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                    input int nwait, input bit slv, output logic [31:0] rd,
                                    output logic er, output int lat, output int npsel);
    longint off;
    int     idx;
    off = longint'({32'b0, addr}) - longint'({32'b0, Base});
    if (off < 0 || off >= longint'({32'b0, Win}) || addr[1:0] != 2'b00) begin
      rd = 0; er = 1'b1; lat = 1; npsel = 0;
      return;
    end
    idx = int'(off >>> 2);
    if (nwait >= int'(Timeout)) begin
      rd = 0; er = 1'b1; lat = 2 + int'(Timeout); npsel = 1 + int'(Timeout);
      return;
    end
    lat   = 3 + nwait;
    npsel = 2 + nwait;
    er    = slv;
    rd    = wr ? 32'h0 : (ref_vld[idx] ? ref_mem[idx] : dflt(idx));
    if (wr && !slv) begin
      ref_mem[idx] = wdata;
      ref_vld[idx] = 1'b1;
    end
  endfunction

  function automatic void ref_write(input logic [31:0] addr, input logic [31:0] wdata);
    int idx;
    idx = int'((addr - Base) >> 2);
    ref_mem[idx] = wdata;
    ref_vld[idx] = 1'b1;
  endfunction

  // Issues one request, measures response latency (cycles after the handshake edge),
  // counts Psel cycles and watches APB/response stability; holds rsp_ready low 'hold' cycles.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int nwait, input bit slv, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int npsel, output bit proto_ok);
    int k;
    rdata = 'x; err = 'x; lat = -1; npsel = 0; proto_ok = 1'b1;
    @(negedge Pclk);
    wait_n        = nwait;
    slverr_en     = slv;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(negedge Pclk);
      k++;
    end
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_wait: got req_ready=0 for 50 cycles, want 1");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge Pclk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 100 && lat < 0; c++) begin
      @(negedge Pclk);
      if (bus.Psel) begin
        npsel++;
        if (bus.Paddr !== addr || bus.Pwrite !== wr || (wr && bus.Pwdata !== wdata) ||
            bus.Penable !== (npsel > 1)) proto_ok = 1'b0;
      end
      if (bus.rsp_valid) begin
        lat = c;
        if (bus.Psel || bus.Penable || bus.req_ready) proto_ok = 1'b0;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL rsp_valid_wait: got no rsp_valid in 100 cycles, want a response");
      return;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = Base + 32'h10;
      @(negedge Pclk);
      if (!bus.rsp_valid || bus.rsp_rdata !== rdata || bus.rsp_err !== err || bus.req_ready ||
          bus.Psel || bus.Penable || bus.Paddr !== addr) proto_ok = 1'b0;
    end
    bus.req_valid = 1'b0;
    bus.req_addr  = addr;
    bus.rsp_ready = 1'b1;
    @(posedge Pclk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          nwait;
    bit          slv;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int nwait, input bit slv, input int hold, input logic exp_err,
                     input logic [31:0] exp_rd, input int exp_lat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.nwait = nwait; v.slv = slv; v.hold = hold;
    v.exp_err = exp_err; v.exp_rd = exp_rd; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, m_rd;
    logic        er, m_er;
    int          lat, m_lat, ps, m_ps;
    bit          pok;
    vec_t        v;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    Prst_n        = 1'b0;

    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_psel", bus.Psel, 0);
    check("rst_penable", bus.Penable, 0);
    check("rst_paddr", bus.Paddr, 0);
    check("rst_pwrite", bus.Pwrite, 0);
    check("rst_pwdata", bus.Pwdata, 0);
    repeat (3) @(negedge Pclk);
    Prst_n = 1'b1;
    @(posedge Pclk);
    #1 check("req_ready_after_reset", bus.req_ready, 1);

    // wr, addr, wdata, wait, slverr, hold, exp_err, exp_rdata, exp_latency
    add(1, Base + LED, 32'h1234_5678, 0, 0, 0, 0, 32'h0, 3);
    add(0, Base + LED, 32'h0, 0, 0, 0, 0, 32'h1234_5678, 3);
    add(0, Base + SW1, 32'h0, 3, 0, 0, 0, 32'hA5A5_A5A5, 6);
    add(0, 32'h3000_0000, 32'h0, 0, 0, 0, 1, 32'h0, 1);
    add(0, 32'h2000_0002, 32'h0, 0, 0, 0, 1, 32'h0, 1);
    add(0, Base + SW2, 32'h0, 100, 0, 0, 1, 32'h0, 18);
    add(1, Base + SW2, 32'h0000_00FF, 1, 0, 0, 0, 32'h0, 4);
    add(0, Base + SW2, 32'h0, 0, 1, 0, 1, 32'h0000_00FF, 3);
    add(0, Base + SW2, 32'h0, 0, 0, 5, 0, 32'h0000_00FF, 3);
    add(0, 32'h1FFF_FFFC, 32'h0, 0, 0, 0, 1, 32'h0, 1);
    add(0, 32'h2000_0FFC, 32'h0, 0, 0, 0, 0, 32'hC0DE_03FF, 3);
    add(0, 32'h2000_1000, 32'h0, 0, 0, 0, 1, 32'h0, 1);
    add(0, 32'hFFFF_FFFC, 32'h0, 0, 0, 0, 1, 32'h0, 1);
    add(1, Base + SW1, 32'h5A5A_0001, 15, 0, 0, 0, 32'h0, 18);
    add(0, Base + SW1, 32'h0, 0, 0, 0, 0, 32'h5A5A_0001, 3);

    foreach (vecs[i]) begin
      v = vecs[i];
      do_req(v.wr, v.addr, v.wdata, v.nwait, v.slv, v.hold, rd, er, lat, ps, pok);
      if (v.wr && !v.slv && !v.exp_err) ref_write(v.addr, v.wdata);
      check($sformatf("vec%0d_err", i), er, v.exp_err);
      check($sformatf("vec%0d_rdata", i), rd, v.exp_rd);
      check($sformatf("vec%0d_latency", i), lat, v.exp_lat);
      check($sformatf("vec%0d_psel_cycles", i), ps, (v.exp_lat == 1) ? 0 : v.exp_lat - 1);
      check($sformatf("vec%0d_protocol", i), pok, 1);
    end

    // Reset pulsed while the responder stalls in ACCESS.
    @(negedge Pclk);
    wait_n        = 50;
    slverr_en     = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = Base + LED;
    @(posedge Pclk);
    #1 bus.req_valid = 1'b0;
    repeat (3) @(negedge Pclk);
    check("mid_penable_before_reset", bus.Penable, 1);
    #2 Prst_n = 1'b0;
    #1;
    check("mid_rst_psel", bus.Psel, 0);
    check("mid_rst_penable", bus.Penable, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_req_ready", bus.req_ready, 0);
    check("mid_rst_paddr", bus.Paddr, 0);
    @(negedge Pclk);
    Prst_n = 1'b1;
    @(posedge Pclk);
    #1 check("mid_rst_req_ready_after", bus.req_ready, 1);
    do_req(1, Base + SEG, 32'hCAFE_0001, 0, 0, 0, rd, er, lat, ps, pok);
    ref_write(Base + SEG, 32'hCAFE_0001);
    check("seg_write_err", er, 0);
    check("seg_write_latency", lat, 3);
    check("seg_write_protocol", pok, 1);
    do_req(0, Base + SEG, 32'h0, 0, 0, 0, rd, er, lat, ps, pok);
    check("seg_read_rdata", rd, 32'hCAFE_0001);
    check("seg_read_err", er, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 200; n++) begin
      bit          wr, slv;
      logic [31:0] addr, wdata;
      int          nwait, hold, r;
      r = int'($urandom_range(0, 9));
      if (r < 7) addr = Base + ($urandom_range(0, 15) << 2);
      else if (r == 7) addr = Base + (($urandom_range(0, 1023) << 2) | 32'($urandom_range(1, 3)));
      else addr = $urandom();
      wr    = 1'($urandom_range(0, 1));
      wdata = $urandom();
      nwait = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(14, 20));
      slv   = ($urandom_range(0, 7) == 0);
      hold  = int'($urandom_range(0, 2));
      ref_model(wr, addr, wdata, nwait, slv, m_rd, m_er, m_lat, m_ps);
      do_req(wr, addr, wdata, nwait, slv, hold, rd, er, lat, ps, pok);
      check($sformatf("rnd%0d_err", n), er, m_er);
      check($sformatf("rnd%0d_rdata", n), rd, m_rd);
      check($sformatf("rnd%0d_latency", n), lat, m_lat);
      check($sformatf("rnd%0d_psel_cycles", n), ps, m_ps);
      check($sformatf("rnd%0d_protocol", n), pok, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Initiator end of the APB link used by the peripheral block: converts a single-outstanding valid/ready request from the core-side load/store path into APB SETUP/ACCESS transfers and returns read data and error status on a valid/ready response channel. It sits between the core's MMIO port and every APB responder in the address window starting at 0x2000_0000 (LED, SW1, SW2, SEG, and later additions). It adds address-window/alignment decode errors and a stuck-slave timeout, so a missing or hung responder cannot lock the core.

## Interface
Parameters:
- BASE_ADDR, 32'h2000_0000, first byte address of the APB window
- WIN_SIZE, 32'h0000_1000, window size in bytes; legal addresses are BASE_ADDR <= a < BASE_ADDR+WIN_SIZE
- TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables the timeout

Ports:
- Pclk  in  1  the block's only clock
- Prst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  32  byte address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  Pslverr, decode error or timeout
- Paddr  out  32  APB address
- Pwrite  out  1  APB direction
- Psel  out  1  APB select
- Penable  out  1  APB access phase
- Pwdata  out  32  APB write data
- Prdata  in  32  APB read data
- Pready  in  1  APB ready
- Pslverr  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready=1. On handshake, latch addr/write/wdata into Paddr/Pwrite/Pwdata (held stable until the next accepted request).
  - Legal address (in window, req_addr[1:0]==0): go to SETUP.
  - Otherwise: go directly to RESP with rsp_err=1, rsp_rdata=0, no APB activity.
- SETUP: Psel=1, Penable=0; always go to ACCESS next cycle. Clear the timeout counter.
- ACCESS: Psel=1, Penable=1.
  - Pready=1: capture rsp_rdata=Pwrite?0:Prdata and rsp_err=Pslverr, then go to RESP.
  - Pready=0: increment the counter. When TIMEOUT!=0 and the counter reaches TIMEOUT-1, abort: rsp_err=1, rsp_rdata=0, go to RESP.
- RESP: rsp_valid=1, Psel=Penable=0, rsp_* held stable. Go to IDLE on rsp_ready. req_ready=0 here, so only one transfer is ever outstanding.
- Counter width is $clog2(TIMEOUT+1), with a minimum of 1 bit. It saturates and never wraps.
- Window check is done without overflow: compute (req_addr - BASE_ADDR) in 33 bits and compare against WIN_SIZE.

## Timing
- Reset values: req_ready=0 during reset, then 1 from the first cycle after deassertion (state IDLE). rsp_valid=0, rsp_rdata=0, rsp_err=0, Psel=0, Penable=0, Paddr=0, Pwrite=0, Pwdata=0.
- Zero-wait-state transfer: handshake at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3. Each Pready-low cycle adds one cycle.
- Decode error: rsp_valid in the cycle after the handshake.
- Earliest next request: the cycle after the rsp handshake. Minimum request-to-request spacing is 4 cycles.
- All outputs are registered or decoded from the state register only. There is no combinational path from Pready/Prdata to any output.
- Reset asserted mid-transfer: Psel/Penable drop immediately (asynchronous), any pending response is discarded, the FSM returns to IDLE.
- Pslverr is sampled only when Pready=1 in ACCESS and is ignored otherwise.

## Structure
- Shared package apb_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP)
  - APB_ADDR_W=32 and APB_DATA_W=32
  - peripheral register offsets LED=0x0, SW1=0x4, SW2=0x8, SEG=0xC, for the bench and firmware
- Single module; no sub-module. The timeout counter is inline.

## Test plan
- Write 0x1234_5678 to 0x2000_0000, responder Pready=1 -> Psel rises at cycle 1, Penable at cycle 2; rsp_valid at cycle 3 with rsp_err=0 and rsp_rdata=0; LED reads back 0x1234_5678.
- Read 0x2000_0004 with SW1=0xA5A5_A5A5, Pready held low for 3 ACCESS cycles -> Paddr/Psel/Penable stable throughout; rsp_valid at cycle 6 with rdata 0xA5A5_A5A5.
- Read 0x3000_0000, then read 0x2000_0002 -> each gives rsp_valid the cycle after the handshake with rsp_err=1 and no Psel pulse.
- TIMEOUT=16, Pready tied 0 -> Psel/Penable drop after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0; the next request proceeds normally.
- Pslverr=1 with Pready=1 on a read -> rsp_err=1 with rdata = Prdata. Separately, hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, no new APB transfer.
- Prst_n pulsed low during ACCESS -> Psel=Penable=0 at once, rsp_valid=0; after release req_ready=1 and a write to 0x2000_000C succeeds.
